// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word and field positions.
// The HALT state exists only when IFU_MISALIGN_TRAP_EN is defined.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    ST_HALT = 3'd4
`endif
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          OPCODE_MSB = 6;
  localparam int          OPCODE_LSB = 0;
  localparam int          FUNCT3_MSB = 14;
  localparam int          FUNCT3_LSB = 12;
  localparam int          FUNCT7_MSB = 31;
  localparam int          FUNCT7_LSB = 25;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: owns the PC, fetches words, holds one instruction for decode.
// Define IFU_MISALIGN_TRAP_EN to halt on misaligned redirects instead of forcing word alignment.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fetch_misalign
);
  import instr_fetch_unit_pkg::*;

  ifu_state_e  state_r;
  logic [31:0] pc_r;
  logic        discard_r;
  logic        req_valid_r;
  logic [31:0] req_addr_r;
  logic        instr_valid_r;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic        misalign_r;

  logic        req_fire_s;
  logic [31:0] target_s;
  logic        trap_s;

  assign req_fire_s = req_valid_r & imem_req_ready;

  // Redirect target conditioning and misalignment trap detection
  always_comb begin
    target_s = redirect_target;
    trap_s   = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    trap_s   = redirect_valid & is_misaligned(redirect_target);
`else
    target_s[1:0] = 2'b00;
`endif
  end

  // Fetch FSM with PC, discard flag and instruction output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      discard_r     <= 1'b0;
      req_valid_r   <= 1'b0;
      req_addr_r    <= RESET_PC;
      instr_valid_r <= 1'b0;
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= RESET_PC;
      misalign_r    <= 1'b0;
    end else begin
`ifdef IFU_MISALIGN_TRAP_EN
      if (trap_s && (state_r != ST_HALT)) begin
        state_r       <= ST_HALT;
        misalign_r    <= 1'b1;
        req_valid_r   <= 1'b0;
        instr_valid_r <= 1'b0;
        discard_r     <= 1'b0;
      end else
`endif
      begin
        case (state_r)
          ST_BOOT: begin
            state_r     <= ST_REQ;
            req_valid_r <= 1'b1;
            if (redirect_valid) begin
              pc_r       <= target_s;
              req_addr_r <= target_s;
            end else begin
              req_addr_r <= pc_r;
            end
          end
          ST_REQ: begin
            if (redirect_valid) begin
              pc_r          <= target_s;
              req_addr_r    <= target_s;
              instr_valid_r <= 1'b0;
              if (req_fire_s) begin
                // the accepted request returns stale data; drop it on arrival
                state_r     <= ST_WAIT;
                req_valid_r <= 1'b0;
                discard_r   <= 1'b1;
              end else begin
                req_valid_r <= 1'b1;
              end
            end else if (req_fire_s) begin
              state_r     <= ST_WAIT;
              req_valid_r <= 1'b0;
            end else begin
              req_valid_r <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (redirect_valid) begin
              pc_r          <= target_s;
              instr_valid_r <= 1'b0;
              if (imem_rsp_valid) begin
                discard_r   <= 1'b0;
                state_r     <= ST_REQ;
                req_valid_r <= 1'b1;
                req_addr_r  <= target_s;
              end else begin
                discard_r <= 1'b1;
              end
            end else if (imem_rsp_valid) begin
              if (discard_r) begin
                discard_r   <= 1'b0;
                state_r     <= ST_REQ;
                req_valid_r <= 1'b1;
                req_addr_r  <= pc_r;
              end else begin
                instr_r       <= imem_rsp_data;
                instr_pc_r    <= pc_r;
                pc_r          <= pc_incr(pc_r);
                instr_valid_r <= 1'b1;
                state_r       <= ST_HOLD;
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end
          ST_HOLD: begin
            if (redirect_valid) begin
              pc_r          <= target_s;
              instr_valid_r <= 1'b0;
              state_r       <= ST_REQ;
              req_valid_r   <= 1'b1;
              req_addr_r    <= target_s;
            end else if (instr_ready) begin
              instr_valid_r <= 1'b0;
              state_r       <= ST_REQ;
              req_valid_r   <= 1'b1;
              req_addr_r    <= pc_r;
            end else begin
              state_r <= ST_HOLD;
            end
          end
`ifdef IFU_MISALIGN_TRAP_EN
          ST_HALT: begin
            state_r <= ST_HALT;
          end
`endif
          default: begin
            state_r       <= ST_BOOT;
            req_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
            discard_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = req_addr_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign instr_pc       = instr_pc_r;
  assign fetch_misalign = misalign_r;
  assign opcode         = instr_r[OPCODE_MSB:OPCODE_LSB];
  assign funct3         = instr_r[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7         = instr_r[FUNCT7_MSB:FUNCT7_LSB];

endmodule
